// File: rtl/l1_mem_pkg.sv
package l1_mem_pkg;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_WORD_W     = 32;
  localparam int unsigned DEF_LINE_WORDS = 4;

  typedef enum logic [2:0] {
    BR_IDLE    = 3'd0,
    BR_WRITE   = 3'd1,
    BR_READ    = 3'd2,
    BR_DONE    = 3'd3,
    BR_RECOVER = 3'd4
  } br_state_e;

  function automatic int unsigned beat_idx_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned offset_bits(input int unsigned line_words);
    return $clog2(line_words) + 2;
  endfunction

endpackage

// File: rtl/sat_counter16.sv
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/l1_mem_bridge.sv
module l1_mem_bridge
  import l1_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned WORD_W     = DEF_WORD_W,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_cs,
  input  logic                         mem_we,
  input  logic                         mem_wb,
  input  logic [ADDR_W-1:0]            mem_addr,
  input  logic [LINE_WORDS*WORD_W-1:0] mem_line_wdata,
  output logic                         ext_mem_ack,
  output logic [LINE_WORDS*WORD_W-1:0] mem_line_rdata,
  output logic                         bus_req,
  output logic                         bus_we,
  output logic [ADDR_W-1:0]            bus_addr,
  output logic [WORD_W-1:0]            bus_wdata,
  input  logic [WORD_W-1:0]            bus_rdata,
  input  logic                         bus_ready,
  output logic                         busy,
  output logic [15:0]                  wb_count,
  output logic [15:0]                  fill_count
);

  localparam int unsigned OFFSET = offset_bits(LINE_WORDS);
  localparam int unsigned IDX_W  = beat_idx_w(LINE_WORDS);
  localparam int unsigned TAG_W  = ADDR_W - OFFSET;
  localparam int unsigned LINE_W = LINE_WORDS * WORD_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  br_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              we_q, we_d;
  logic              wb_q, wb_d;
  logic [LINE_W-1:0] wline_q, wline_d;
  logic [LINE_W-1:0] rline_q, rline_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [WORD_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;

  logic              beat_done;
  logic              last_beat;
  logic [IDX_W-1:0]  next_idx;
  logic              wb_inc;
  logic              fill_inc;
  logic              unused_bits;

  // bus_ready only counts while a beat is actually being offered
  assign beat_done = bus_req_q && bus_ready;
  assign last_beat = beat_done && (idx_q == LAST_IDX);
  assign next_idx  = idx_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BR_IDLE: begin
        if (mem_cs) begin
          state_d = mem_we ? BR_WRITE : BR_READ;
        end
      end
      BR_WRITE, BR_READ: begin
        if (last_beat) begin
          state_d = BR_DONE;
        end
      end
      BR_DONE:    state_d = BR_RECOVER;
      BR_RECOVER: state_d = BR_IDLE;
      default:    state_d = BR_IDLE;
    endcase
  end

  // ack/busy are decoded from the next state so they leave a flop
  always_comb begin
    idx_d       = idx_q;
    tag_d       = tag_q;
    we_d        = we_q;
    wb_d        = wb_q;
    wline_d     = wline_q;
    rline_d     = rline_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    ack_d       = (state_d == BR_DONE);
    busy_d      = (state_d != BR_IDLE);

    unique case (state_q)
      BR_IDLE: begin
        if (mem_cs) begin
          tag_d       = mem_addr[ADDR_W-1:OFFSET];
          we_d        = mem_we;
          wb_d        = mem_wb;
          wline_d     = mem_line_wdata;
          idx_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we;
          bus_addr_d  = {mem_addr[ADDR_W-1:OFFSET], {IDX_W{1'b0}}, 2'b00};
          bus_wdata_d = mem_line_wdata[WORD_W-1:0];
        end
      end
      BR_WRITE, BR_READ: begin
        if (beat_done) begin
          if (state_q == BR_READ) begin
            for (int unsigned i = 0; i < LINE_WORDS; i++) begin
              if (idx_q == IDX_W'(i)) begin
                rline_d[i*WORD_W +: WORD_W] = bus_rdata;
              end
            end
          end
          if (idx_q == LAST_IDX) begin
            idx_d     = '0;
            bus_req_d = 1'b0;
            bus_we_d  = 1'b0;
          end else begin
            idx_d      = next_idx;
            bus_addr_d = {tag_q, next_idx, 2'b00};
            for (int unsigned i = 0; i < LINE_WORDS; i++) begin
              if (next_idx == IDX_W'(i)) begin
                bus_wdata_d = wline_q[i*WORD_W +: WORD_W];
              end
            end
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      tag_q       <= '0;
      we_q        <= 1'b0;
      wb_q        <= 1'b0;
      wline_q     <= '0;
      rline_q     <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      tag_q       <= tag_d;
      we_q        <= we_d;
      wb_q        <= wb_d;
      wline_q     <= wline_d;
      rline_q     <= rline_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  // counters step on entry to DONE so they update together with the ack
  assign wb_inc   = ack_d && we_q;
  assign fill_inc = ack_d && !we_q;

  sat_counter16 u_wb_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wb_inc),
    .count (wb_count)
  );

  sat_counter16 u_fill_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (fill_inc),
    .count (fill_count)
  );

  assign unused_bits = ^{mem_addr[OFFSET-1:0], wb_q};

  assign ext_mem_ack    = ack_q;
  assign mem_line_rdata = rline_q;
  assign bus_req        = bus_req_q;
  assign bus_we         = bus_we_q;
  assign bus_addr       = bus_addr_q;
  assign bus_wdata      = bus_wdata_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_l1_mem_bridge.sv
module tb_l1_mem_bridge;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_cs = 1'b0;
  logic         mem_we = 1'b0;
  logic         mem_wb = 1'b0;
  logic [31:0]  mem_addr = '0;
  logic [127:0] mem_line_wdata = '0;
  logic         ext_mem_ack;
  logic [127:0] mem_line_rdata;
  logic         bus_req;
  logic         bus_we;
  logic [31:0]  bus_addr;
  logic [31:0]  bus_wdata;
  logic [31:0]  bus_rdata;
  logic         bus_ready = 1'b1;
  logic         busy;
  logic [15:0]  wb_count;
  logic [15:0]  fill_count;

  logic         sat_inc = 1'b0;
  logic         sat_clr = 1'b1;
  logic [15:0]  sat_count;
  bit           sat_done = 0;

  int           n_cmp = 0;
  int           n_fail = 0;
  int           n_ack = 0;
  logic [31:0]  rd_base = 32'h0;
  bit           rand_ready = 0;
  int           stall_left = 0;

  always #5 clk = ~clk;

  l1_mem_bridge #(.ADDR_W(32), .WORD_W(32), .LINE_WORDS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_cs         (mem_cs),
    .mem_we         (mem_we),
    .mem_wb         (mem_wb),
    .mem_addr       (mem_addr),
    .mem_line_wdata (mem_line_wdata),
    .ext_mem_ack    (ext_mem_ack),
    .mem_line_rdata (mem_line_rdata),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .bus_ready      (bus_ready),
    .busy           (busy),
    .wb_count       (wb_count),
    .fill_count     (fill_count)
  );

  sat_counter16 u_sat (
    .clk   (clk),
    .rst   (sat_clr),
    .inc   (sat_inc),
    .count (sat_count)
  );

  // memory returns rd_base + word index within the line
  assign bus_rdata = rd_base + {30'd0, bus_addr[3:2]};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // transaction-level model: beats remaining, beat number, cooldown after a line
  int           m_left = 0;
  int           m_beat = 0;
  int           m_cool = 0;
  logic         m_ack = 1'b0;
  logic [27:0]  m_tag = '0;
  logic         m_we = 1'b0;
  logic [127:0] m_wline = '0;
  logic [127:0] m_rline = '0;
  logic [15:0]  m_wb = '0;
  logic [15:0]  m_fill = '0;

  always @(posedge clk or posedge rst) begin : model
    int           left, beat, cool;
    logic         ack;
    logic [127:0] rline;
    logic [15:0]  wbc, fillc;
    if (rst) begin
      m_left <= 0; m_beat <= 0; m_cool <= 0; m_ack <= 1'b0;
      m_rline <= '0; m_wb <= '0; m_fill <= '0;
    end else begin
      left = m_left; beat = m_beat; cool = m_cool; ack = 1'b0;
      rline = m_rline; wbc = m_wb; fillc = m_fill;
      if (left > 0) begin
        if (bus_ready) begin
          if (!m_we) rline[beat*32 +: 32] = rd_base + 32'(beat);
          beat = beat + 1;
          left = left - 1;
          if (left == 0) begin
            ack = 1'b1;
            cool = 2;
            if (m_we) wbc = (wbc == 16'hFFFF) ? wbc : wbc + 16'd1;
            else      fillc = (fillc == 16'hFFFF) ? fillc : fillc + 16'd1;
          end
        end
      end else if (cool > 0) begin
        cool = cool - 1;
      end else if (mem_cs) begin
        left = 4;
        beat = 0;
        m_tag   <= mem_addr[31:4];
        m_we    <= mem_we;
        m_wline <= mem_line_wdata;
      end
      m_left <= left; m_beat <= beat; m_cool <= cool; m_ack <= ack;
      m_rline <= rline; m_wb <= wbc; m_fill <= fillc;
    end
  end

  always @(negedge clk) begin : compare
    check("ack", 128'(ext_mem_ack), 128'(m_ack));
    check("busy", 128'(busy), 128'((m_left > 0) || (m_cool > 0)));
    check("bus_req", 128'(bus_req), 128'(m_left > 0));
    if (m_left > 0) begin
      check("bus_we", 128'(bus_we), 128'(m_we));
      check("bus_addr", 128'(bus_addr), 128'({m_tag, m_beat[1:0], 2'b00}));
      if (m_we) check("bus_wdata", 128'(bus_wdata), 128'(m_wline[m_beat*32 +: 32]));
    end
    check("line_rdata", mem_line_rdata, m_rline);
    check("wb_count", 128'(wb_count), 128'(m_wb));
    check("fill_count", 128'(fill_count), 128'(m_fill));
    if (ext_mem_ack) n_ack++;
  end

  always begin : responder
    @(posedge clk); #1;
    if (!rand_ready) begin
      bus_ready = 1'b1;
    end else begin
      if (bus_ready) stall_left = $urandom_range(0, 3);
      else           stall_left = stall_left - 1;
      bus_ready = (stall_left == 0);
    end
  end

  task automatic request(input logic [31:0] addr, input logic we, input logic wb,
                         input logic [127:0] line);
    @(posedge clk); #1;
    mem_cs = 1'b1; mem_we = we; mem_wb = wb; mem_addr = addr; mem_line_wdata = line;
    @(posedge clk); #1;
    mem_cs = 1'b0;
  endtask

  task automatic wait_ack(input string name, input int limit);
    bit got = 0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (ext_mem_ack) got = 1;
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s: no ack within %0d cycles, expected one", name, limit);
    end
  endtask

  task automatic do_xfer(input logic [31:0] addr, input logic we, input logic [127:0] line);
    request(addr, we, we, line);
    wait_ack("xfer_ack", 100);
    repeat (2) @(negedge clk);
  endtask

  initial begin : sat_test
    repeat (2) @(posedge clk);
    #1 sat_clr = 1'b0;
    @(negedge clk);
    check("sat_clear", 128'(sat_count), 128'(16'h0000));
    @(posedge clk); #1 sat_inc = 1'b1;
    repeat (65534) @(posedge clk);
    #1 check("sat_fffe", 128'(sat_count), 128'(16'hFFFE));
    @(posedge clk);
    #1 check("sat_ffff", 128'(sat_count), 128'(16'hFFFF));
    repeat (5) @(posedge clk);
    #1 check("sat_stick", 128'(sat_count), 128'(16'hFFFF));
    sat_inc = 1'b0;
    @(posedge clk);
    #1 check("sat_hold", 128'(sat_count), 128'(16'hFFFF));
    sat_done = 1;
  end

  initial begin : main
    logic [31:0] exp_addr [4];
    int          acks;
    int          ack_before;
    bit          started;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ack", 128'(ext_mem_ack), 128'(0));
    check("rst_req", 128'(bus_req), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_line", mem_line_rdata, 128'(0));
    @(posedge clk); #1 rst = 1'b0;

    // read, ready high, line at 0x1234
    rd_base = 32'hA0;
    exp_addr = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
    request(32'h0000_1234, 1'b0, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rd_addr", 128'(bus_addr), 128'(exp_addr[k]));
      check("rd_req", 128'({bus_req, bus_we}), 128'(2'b10));
      check("rd_noack", 128'(ext_mem_ack), 128'(0));
    end
    @(negedge clk);
    check("rd_ack", 128'(ext_mem_ack), 128'(1));
    check("rd_line", mem_line_rdata, 128'h000000A3_000000A2_000000A1_000000A0);
    check("rd_fill", 128'(fill_count), 128'(1));
    @(negedge clk);
    check("rd_recover", 128'({ext_mem_ack, busy}), 128'(2'b01));
    @(negedge clk);
    check("rd_idle", 128'(busy), 128'(0));

    // write-back
    request(32'h0000_2000, 1'b1, 1'b1, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("wr_wdata", 128'(bus_wdata), 128'(32'hD0 + k));
      check("wr_we", 128'(bus_we), 128'(1));
    end
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ext_mem_ack) acks++;
    end
    check("wr_single_ack", 128'(acks), 128'(1));
    check("wr_count", 128'(wb_count), 128'(1));

    // write-back then allocate with mem_cs held high
    rd_base = 32'h5000_0000;
    @(posedge clk); #1;
    mem_cs = 1'b1; mem_we = 1'b1; mem_wb = 1'b1; mem_addr = 32'h0000_3000;
    mem_line_wdata = {32'h13, 32'h12, 32'h11, 32'h10};
    @(posedge clk); #1;
    mem_we = 1'b0; mem_wb = 1'b0;
    wait_ack("wbrd_wr_ack", 20);
    @(negedge clk);
    check("wbrd_gap1", 128'(bus_req), 128'(0));
    @(negedge clk);
    check("wbrd_gap2", 128'(bus_req), 128'(0));
    @(negedge clk);
    check("wbrd_start", 128'({bus_req, bus_we}), 128'(2'b10));
    check("wbrd_addr", 128'(bus_addr), 128'(32'h3000));
    mem_cs = 1'b0;
    wait_ack("wbrd_rd_ack", 20);
    repeat (2) @(negedge clk);
    check("wbrd_wb", 128'(wb_count), 128'(2));
    check("wbrd_fill", 128'(fill_count), 128'(2));
    check("wbrd_line", mem_line_rdata, 128'h50000003_50000002_50000001_50000000);

    // random stalls
    rand_ready = 1;
    rd_base = 32'h7700_0000;
    ack_before = n_ack;
    for (int t = 0; t < 8; t++) begin
      do_xfer($urandom, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
    end
    check("stall_ack_count", 128'(n_ack - ack_before), 128'(8));
    rand_ready = 0;
    repeat (2) @(negedge clk);

    // reset in the middle of beat 2 of a read
    rd_base = 32'hC0;
    request(32'h0000_4440, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    check("abort_beat2", 128'(bus_addr), 128'(32'h4448));
    #2 rst = 1'b1;
    #1;
    check("abort_ack", 128'(ext_mem_ack), 128'(0));
    check("abort_bus", 128'({bus_req, bus_we, bus_addr, bus_wdata}), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_cnt", 128'({wb_count, fill_count}), 128'(0));
    check("abort_line", mem_line_rdata, 128'(0));
    ack_before = n_ack;
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_ack", 128'(n_ack - ack_before), 128'(0));
    do_xfer(32'h0000_4440, 1'b0, '0);
    check("after_rst_fill", 128'(fill_count), 128'(1));
    check("after_rst_line", mem_line_rdata, 128'h000000C3_000000C2_000000C1_000000C0);

    // saturation counter sequence runs in parallel
    started = 0;
    for (int i = 0; i < 80000 && !sat_done; i++) @(posedge clk);
    n_cmp++;
    if (!sat_done) begin
      n_fail++;
      $display("FAIL sat_timeout: counter sequence not done, expected done");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_mem_bridge.md
# l1_mem_bridge

Bridge between the L1 cache controller's external-memory control signals and the word-wide external memory bus. It turns one cache-line request (write-back or allocate) into a burst of `LINE_WORDS` single-word bus beats. It assembles read data into a full line and returns a one-cycle `ext_mem_ack` to the controller. It also keeps saturating write-back and fill counters for performance monitoring.

## Interface
- `ADDR_W`, 32, byte-address width
- `WORD_W`, 32, bus word width
- `LINE_WORDS`, 4, words per cache line (power of two, ≥2)

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `mem_cs`  in  1  line transfer requested by cache controller
- `mem_we`  in  1  1 = write line to memory, 0 = read line
- `mem_wb`  in  1  request is a dirty-line write-back (counted only)
- `mem_addr`  in  ADDR_W  line address; low `OFFSET` bits ignored
- `mem_line_wdata`  in  LINE_WORDS*WORD_W  victim line; word i at `[i*WORD_W +: WORD_W]`
- `ext_mem_ack`  out  1  one-cycle pulse: transfer complete
- `mem_line_rdata`  out  LINE_WORDS*WORD_W  filled line, valid while `ext_mem_ack`=1, held until next read
- `bus_req`  out  1  beat request
- `bus_we`  out  1  beat is a write
- `bus_addr`  out  ADDR_W  word-aligned beat address
- `bus_wdata`  out  WORD_W  beat write data
- `bus_rdata`  in  WORD_W  beat read data, valid with `bus_ready`
- `bus_ready`  in  1  beat accepted/completed this cycle
- `busy`  out  1  state ≠ IDLE
- `wb_count`  out  16  completed write-backs, saturating
- `fill_count`  out  16  completed reads, saturating

## Operation
- `OFFSET` = log2(LINE_WORDS)+2. Beat i address = `{mem_addr[ADDR_W-1:OFFSET], i, 2'b00}`. Beats are issued in order 0..LINE_WORDS-1.
- States: IDLE, WRITE_BURST, READ_BURST, DONE, RECOVER.
- IDLE: at the clock edge where `mem_cs`=1, latch the address, `mem_we`, `mem_wb` and the write line. Go to WRITE_BURST if `mem_we`, otherwise READ_BURST. Load beat 0 onto the bus registers and set `bus_req`=1.
- WRITE_BURST / READ_BURST: `bus_req` stays high. `bus_addr`, `bus_we` and `bus_wdata` are held stable until `bus_ready`=1 is sampled.
  - On each accepted beat, READ_BURST captures `bus_rdata` into line slot i, and the beat index increments.
  - After the last beat: drop `bus_req` and go to DONE.
- DONE: `ext_mem_ack`=1 for exactly this cycle. Increment `wb_count` if the latched `mem_we` is set, otherwise `fill_count`. `mem_wb` is recorded only; it does not select the counter. Then go to RECOVER.
- RECOVER: one cycle during which `mem_cs` is ignored, giving the controller time to update `mem_cs`/`mem_we` after the ack. Then go to IDLE.
- `bus_ready` is ignored whenever `bus_req`=0.
- Counters stick at 16'hFFFF.
- Inputs `mem_*` are don't-care outside the IDLE sampling edge.

## Timing
- Reset (async, any state including mid-burst): state IDLE, beat index 0. Every output is 0: `ext_mem_ack`, `mem_line_rdata`, `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `busy`, `wb_count`, `fill_count`. No ack is issued for an aborted burst.
- All outputs are registered. Zero-wait beats are allowed: `bus_ready` may be high in the first cycle of `bus_req`.
- With `bus_ready` tied high, `ext_mem_ack` is high in the cycle after edge LINE_WORDS+1 counted from the IDLE sampling edge. Throughput is one beat per cycle.
- Each wait cycle (`bus_ready`=0) adds one cycle.
- Minimum spacing from one ack to the next request-sampling edge: 2 edges (DONE→RECOVER→IDLE).
- Write-back followed by allocate: the controller's switch to `mem_we`=0 is sampled in IDLE after RECOVER and starts a READ_BURST with no extra handshake.

## Structure
- Package `l1_mem_pkg` holds:
  - the state enum (`BR_IDLE`, `BR_WRITE`, `BR_READ`, `BR_DONE`, `BR_RECOVER`);
  - `OFFSET` / beat-index width helper functions;
  - the default line geometry constants.
- One sub-module, `sat_counter16`: 16-bit increment-enable counter with async active-high clear and saturation. Instantiated twice.

## Test plan
- Read, ready tied high, `mem_addr`=0x0000_1234:
  - beats at addresses 0x1230, 0x1234, 0x1238, 0x123C;
  - rdata 0xA0..0xA3 yields `mem_line_rdata`={A3,A2,A1,A0};
  - ack 5 edges after sampling; `fill_count`=1.
- Write-back, `mem_we`=`mem_wb`=1, line {D3,D2,D1,D0}:
  - `bus_wdata` D0..D3 with `bus_we`=1;
  - single ack; `wb_count`=1.
- Write-back, then `mem_we` drops to 0 with `mem_cs` held high: read burst starts exactly 2 edges after the ack cycle, and there is no spurious second write.
- Random `bus_ready` stalls of 0–3 cycles per beat: `bus_addr`/`bus_wdata` stay stable while `bus_ready`=0, and the ack count equals the request count.
- `rst` pulsed during beat 2 of a read: all outputs are 0 immediately, with no ack. After release, a new request completes normally.
- 65 540 forced completions: `fill_count` saturates at 0xFFFF.
